// File: rtl/btn_debouncer.sv
// btn_debouncer: per-channel push-button synchronizer and debouncer.
// Each channel runs a synchronizer chain, a saturating stability counter and a
// four-state FSM. The debounced level and the press/release pulses are all
// registered, so btn_raw never reaches an output combinationally.
// Optional feature: define BTN_DEBOUNCER_RELEASE_EN to enable the btn_release
// pulses. Without it, btn_release is held at 0. btn_out and btn_press behave
// the same either way.
module btn_debouncer #(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_out,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    // Width is sized so that DEBOUNCE_CYCLES-1 is the largest value ever held.
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        ARM_HI    = 2'd1,
        STABLE_HI = 2'd2,
        ARM_LO    = 2'd3
    } state_t;

    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_ff;
            logic                   sync_bit;
            state_t                 state;
            state_t                 state_next;
            logic [CNT_W-1:0]       cnt;
            logic [CNT_W-1:0]       cnt_next;
            logic                   out_q;
            logic                   out_next;
            logic                   press_q;
            logic                   press_next;
            logic                   rel_q;
            logic                   rel_next;

            // Shift the raw pin through the synchronizer chain; the top bit is the safe sample.
            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    sync_ff <= '0;
                end else begin
                    sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_raw[i]};
                end
            end

            assign sync_bit = sync_ff[SYNC_STAGES-1];

            // Hold FSM state, counter and the registered outputs; reset abandons any pending transition.
            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    state   <= STABLE_LO;
                    cnt     <= '0;
                    out_q   <= 1'b0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                end else begin
                    state   <= state_next;
                    cnt     <= cnt_next;
                    out_q   <= out_next;
                    press_q <= press_next;
                    rel_q   <= rel_next;
                end
            end

            // Next-state logic: arm on a level change, commit only after the level has held long enough.
            always_comb begin
                state_next = state;
                cnt_next   = cnt;
                out_next   = out_q;
                press_next = 1'b0;
                rel_next   = 1'b0;
                case (state)
                    STABLE_LO: begin
                        if (sync_bit) begin
                            state_next = ARM_HI;
                            cnt_next   = CNT_ONE;
                        end else begin
                            cnt_next   = '0;
                        end
                    end
                    ARM_HI: begin
                        if (!sync_bit) begin
                            state_next = STABLE_LO;
                            cnt_next   = '0;
                        end else if (cnt == CNT_LAST) begin
                            state_next = STABLE_HI;
                            cnt_next   = '0;
                            out_next   = 1'b1;
                            press_next = 1'b1;
                        end else begin
                            cnt_next   = cnt + CNT_ONE;
                        end
                    end
                    STABLE_HI: begin
                        if (!sync_bit) begin
                            state_next = ARM_LO;
                            cnt_next   = CNT_ONE;
                        end else begin
                            cnt_next   = '0;
                        end
                    end
                    ARM_LO: begin
                        if (sync_bit) begin
                            state_next = STABLE_HI;
                            cnt_next   = '0;
                        end else if (cnt == CNT_LAST) begin
                            state_next = STABLE_LO;
                            cnt_next   = '0;
                            out_next   = 1'b0;
`ifdef BTN_DEBOUNCER_RELEASE_EN
                            rel_next   = 1'b1;
`else
                            rel_next   = 1'b0;
`endif
                        end else begin
                            cnt_next   = cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = STABLE_LO;
                        cnt_next   = '0;
                        out_next   = 1'b0;
                    end
                endcase
            end

            assign btn_out[i]     = out_q;
            assign btn_press[i]   = press_q;
            assign btn_release[i] = rel_q;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: directed self-checking bench for btn_debouncer with
// NUM_BTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8 (10-edge raw-to-output latency).
// Release expectations follow BTN_DEBOUNCER_RELEASE_EN.
module tb_btn_debouncer;

    localparam int DC = 8;

`ifdef BTN_DEBOUNCER_RELEASE_EN
    localparam logic [3:0] EXP_REL0     = 4'b0001;
    localparam int         EXP_REL0_CNT = 1;
`else
    localparam logic [3:0] EXP_REL0     = 4'b0000;
    localparam int         EXP_REL0_CNT = 0;
`endif

    logic       s_axi_aclk;
    logic       s_axi_aresetn;
    logic [3:0] btn_raw;
    logic [3:0] btn_out;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int checks;
    int fails;
    int mon_viol;
    int cycle;
    int press_cnt [4];
    int rel_cnt [4];
    logic [3:0] press_acc;
    logic [3:0] raw_rand;

    btn_debouncer #(
        .NUM_BTN(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .s_axi_aclk(s_axi_aclk),
        .s_axi_aresetn(s_axi_aresetn),
        .btn_raw(btn_raw),
        .btn_out(btn_out),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    // 100 MHz clock
    initial s_axi_aclk = 1'b0;
    always #5 s_axi_aclk = ~s_axi_aclk;

    task automatic check_output(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] value);
        btn_raw = value;
    endtask

    task automatic clear_counts();
        press_acc = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            press_cnt[b] = 0;
            rel_cnt[b]   = 0;
        end
    endtask

    // Advance n rising edges, sampling 1 ns after each and tallying pulses.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge s_axi_aclk);
            #1;
            press_acc = press_acc | btn_press;
            for (int b = 0; b < 4; b++) begin
                press_cnt[b] += int'(btn_press[b]);
                rel_cnt[b]   += int'(btn_release[b]);
            end
        end
    endtask

    // Protocol monitor: press/release exclusivity and per-channel pulse spacing.
    initial begin
        int last_pulse [4];
        for (int b = 0; b < 4; b++) last_pulse[b] = -100;
        mon_viol = 0;
        cycle    = 0;
        forever begin
            @(negedge s_axi_aclk);
            cycle++;
            if ((btn_press & btn_release) != 4'b0000) mon_viol++;
            for (int b = 0; b < 4; b++) begin
                if (btn_press[b] || btn_release[b]) begin
                    if (cycle - last_pulse[b] < DC) mon_viol++;
                    last_pulse[b] = cycle;
                end
            end
        end
    end

    initial begin
        checks = 0;
        fails  = 0;
        s_axi_aresetn = 1'b0;
        btn_raw = 4'b0000;
        clear_counts();

        // Reset state
        step(3);
        check_output("reset_out", btn_out, 4'b0000);
        check_output("reset_press", btn_press, 4'b0000);
        check_output("reset_release", btn_release, 4'b0000);
        s_axi_aresetn = 1'b1;
        step(3);

        // Clean press on bit 0: output changes on the 10th edge
        apply_stimulus(4'b0001);
        step(9);
        check_output("p0_out_edge9", btn_out, 4'b0000);
        check_output("p0_press_edge9", btn_press, 4'b0000);
        step(1);
        check_output("p0_out_edge10", btn_out, 4'b0001);
        check_output("p0_press_edge10", btn_press, 4'b0001);
        step(1);
        check_output("p0_press_one_cycle", btn_press, 4'b0000);
        check_output("p0_out_held", btn_out, 4'b0001);

        // Bounce on bit 1 must be filtered
        clear_counts();
        apply_stimulus(4'b0011); step(5);
        apply_stimulus(4'b0001); step(2);
        apply_stimulus(4'b0011); step(3);
        apply_stimulus(4'b0001); step(12);
        check_output("bounce_out", btn_out, 4'b0001);
        check_output("bounce_no_press", press_acc, 4'b0000);
        apply_stimulus(4'b0011);
        step(9);
        check_output("b1_out_edge9", btn_out, 4'b0001);
        step(1);
        check_output("b1_out_edge10", btn_out, 4'b0011);
        check_output("b1_press_edge10", btn_press, 4'b0010);
        step(10);
        check_int("b1_press_count", press_cnt[1], 1);

        // Release bit 0
        clear_counts();
        apply_stimulus(4'b0010);
        step(9);
        check_output("r0_out_edge9", btn_out, 4'b0011);
        check_output("r0_rel_edge9", btn_release, 4'b0000);
        step(1);
        check_output("r0_out_edge10", btn_out, 4'b0010);
        check_output("r0_rel_edge10", btn_release, EXP_REL0);
        check_output("r0_no_press", btn_press, 4'b0000);
        step(5);
        check_int("r0_rel_count", rel_cnt[0], EXP_REL0_CNT);

        // All four channels at once
        apply_stimulus(4'b0000);
        step(12);
        check_output("all_low_out", btn_out, 4'b0000);
        clear_counts();
        apply_stimulus(4'b1111);
        step(9);
        check_output("all_press_edge9", btn_press, 4'b0000);
        step(1);
        check_output("all_press_edge10", btn_press, 4'b1111);
        check_output("all_out_edge10", btn_out, 4'b1111);
        step(1);
        check_output("all_press_cleared", btn_press, 4'b0000);

        // Reset in the middle of a debounce on bit 2
        apply_stimulus(4'b1000);
        step(12);
        check_output("pre_rst_out", btn_out, 4'b1000);
        clear_counts();
        apply_stimulus(4'b1100);
        step(7);
        s_axi_aresetn = 1'b0;
        #1;
        check_output("rst_async_out", btn_out, 4'b0000);
        check_output("rst_async_press", btn_press, 4'b0000);
        step(2);
        s_axi_aresetn = 1'b1;
        check_output("rst_no_pulse", press_acc, 4'b0000);
        step(9);
        check_output("post_rst_edge9", btn_out, 4'b0000);
        step(1);
        check_output("post_rst_out", btn_out, 4'b1100);
        check_output("post_rst_press", btn_press, 4'b1100);

        // Random bouncing, then settle and compare with the final level
        raw_rand = 4'b1100;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                raw_rand[$urandom_range(0, 3)] ^= 1'b1;
            end
            apply_stimulus(raw_rand);
            step(1);
        end
        step(12);
        check_output("random_settled", btn_out, raw_rand);
        step(2);
        check_int("monitor_violations", mon_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
